mem_fill_arbiter: RTL
=====================

Name: mem_fill_arbiter

Overview:
Shares the single-ported, multi-cycle main memory between the instruction cache and the data cache. It accepts I-miss and D-miss block-fill requests plus D-side write-through stores, and grants one at a time. For a fill it issues one word read per cycle and steers the returned words into the requesting cache with word indices and write enables. It sits between the two caches and main memory, below the pipeline's decode/control stage, and serialises every main-memory transaction.

Parameters:
ADDR_W, 16, address width in bits (byte addressed)
DATA_W, 16, memory word width in bits
WORDS, 8, words per cache block (block = WORDS*2 bytes; power of two)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
icache_miss  in  1  I-cache block fill request, held high until fill_done_i
icache_miss_addr  in  ADDR_W  I-side miss address
dcache_miss  in  1  D-cache block fill request, held high until fill_done_d
dcache_miss_addr  in  ADDR_W  D-side miss address
dcache_wr_req  in  1  write-through store request, held high until wr_ack
dcache_wr_addr  in  ADDR_W  store address
dcache_wr_data  in  DATA_W  store data
mem_en  out  1  memory access strobe
mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_valid  in  1  mem_rdata valid this cycle (one pulse per read issued)
fill_data  out  DATA_W  word to write into the cache (= mem_rdata)
fill_word  out  log2(WORDS)  word index within the block for fill_data
fill_we_i  out  1  write fill_data into the I-cache
fill_we_d  out  1  write fill_data into the D-cache
fill_done_i  out  1  one-cycle pulse: I-fill complete
fill_done_d  out  1  one-cycle pulse: D-fill complete
wr_ack  out  1  one-cycle pulse: store issued to memory
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, issue_cnt=0, recv_cnt=0, base_addr=0, owner=I, last_served=I. All outputs are 0 and mem_addr=0.
- States: IDLE, WRITE, FILL. All mem_*, fill_*, wr_ack and done outputs decode combinationally from registered state, counters and latched fields.
- IDLE arbitration is evaluated each cycle and takes effect at the next edge:
  - dcache_wr_req has the highest priority and goes to WRITE.
  - Otherwise, if exactly one miss is high, that miss goes to FILL.
  - If both misses are high, round-robin applies: the side not equal to last_served wins. After reset this means D wins the first tie.
  - On a fill grant: latch owner, latch base_addr = miss_addr with its low log2(WORDS*2) bits cleared, and clear both counters.
  - On a write grant: latch the store address and data.
- WRITE: lasts exactly one cycle. mem_en=1, mem_wr=1, mem_addr and mem_wdata come from the latched store, wr_ack=1. Next state is IDLE.
- FILL, issue side:
  - While issue_cnt<WORDS: mem_en=1, mem_wr=0, mem_addr = base_addr + 2*issue_cnt, and issue_cnt increments each cycle.
  - Reads are issued on WORDS consecutive cycles with no gaps.
- FILL, return side:
  - On each mem_valid: fill_data=mem_rdata, fill_word=recv_cnt, and the owner's fill_we is 1; recv_cnt increments.
  - Issue and return may overlap in the same cycle.
- FILL completion: the mem_valid that carries word WORDS-1 also asserts the owner's fill_done in that same cycle. last_served becomes owner and next state is IDLE.
- The arbiter is latency-agnostic: it relies on mem_valid only, so memory may return data any number of cycles after issue, in order.
- The IDLE cycle after a fill is mandatory. No back-to-back grant occurs without passing through IDLE.
- A miss_addr change during FILL is ignored because the base is latched.
- A wr_req or miss arriving during FILL/WRITE waits in IDLE arbitration. No request is dropped.
- mem_valid received in IDLE or WRITE is ignored: no fill_we and no counter change.
- A reset mid-FILL aborts the fill with no fill_done pulse. mem_valid pulses arriving after the reset are ignored.
- fill_we_i and fill_we_d are never high in the same cycle. fill_done_x is never high without fill_we_x.

Test Plan:
- I-miss only: icache_miss=1, addr 0x1236, memory latency 4. Expect mem_addr 0x1230, 0x1232 … 0x123E on 8 consecutive cycles with mem_en=1 and mem_wr=0. Expect fill_we_i with fill_word 0..7 on cycles 5..12 after grant, fill_done_i coincident with word 7, busy low the following cycle.
- Store: dcache_wr_req=1, addr 0x0040, data 0xBEEF. Expect one cycle with mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF and wr_ack=1, then IDLE.
- Simultaneous requests after reset: icache_miss, dcache_miss and dcache_wr_req all high. Expect order WRITE, then D-fill, then I-fill. Next I/D tie: D then I.
- Mid-fill arrivals: raise icache_miss and change dcache_miss_addr during a D-fill. Expect D-fill addresses unchanged, and the I-fill granted only after fill_done_d plus one IDLE cycle.
- Irregular memory: mem_valid gaps (latency varying 4–9). Expect fill_word still sequential 0..7, fill_done only on the 8th valid, and no extra mem_en.
- Reset after the 3rd fill_we: assert rst. Expect all outputs 0 immediately, the 5 late mem_valid pulses ignored, and no fill_done. A re-request then fills correctly from word 0.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Serialises main-memory traffic between I-cache fills, D-cache fills and D-side
// write-through stores; fill reads are pipelined and returns are steered by mem_valid.
module mem_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    localparam int WL    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [WL-1:0]     fill_word,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic              fill_done_i,
    output logic              fill_done_d,
    output logic              wr_ack,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_e;
    typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(WORDS * 2 - 1);

    state_e            state_q, state_d;
    logic [WL:0]       issue_q, issue_d;
    logic [WL-1:0]     recv_q, recv_d;
    logic [ADDR_W-1:0] base_q, base_d;
    side_e             owner_q, owner_d;
    side_e             last_q, last_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            issue_q <= '0;
            recv_q  <= '0;
            base_q  <= '0;
            owner_q <= SIDE_I;
            last_q  <= SIDE_I;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            base_q  <= base_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        recv_d      = recv_q;
        base_d      = base_q;
        owner_d     = owner_q;
        last_d      = last_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;
        wr_ack      = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (dcache_wr_req) begin
                    state_d = WRITE;
                    waddr_d = dcache_wr_addr;
                    wdata_d = dcache_wr_data;
                end else if (icache_miss || dcache_miss) begin
                    // On a tie the side that was not served last wins.
                    if (icache_miss && dcache_miss)
                        owner_d = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
                    else
                        owner_d = dcache_miss ? SIDE_D : SIDE_I;
                    base_d  = ((owner_d == SIDE_D) ? dcache_miss_addr : icache_miss_addr) & BLK_MASK;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = FILL;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = wdata_q;
                wr_ack    = 1'b1;
                state_d   = IDLE;
            end
            FILL: begin
                if (issue_q < (WL + 1)'(WORDS)) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'({issue_q[WL-1:0], 1'b0});
                    issue_d  = issue_q + (WL + 1)'(1);
                end
                // Returns are counted independently of issue so any in-order latency works.
                if (mem_valid) begin
                    fill_data = mem_rdata;
                    fill_word = recv_q;
                    fill_we_i = (owner_q == SIDE_I);
                    fill_we_d = (owner_q == SIDE_D);
                    recv_d    = recv_q + WL'(1);
                    if (recv_q == WL'(WORDS - 1)) begin
                        fill_done_i = (owner_q == SIDE_I);
                        fill_done_d = (owner_q == SIDE_D);
                        last_d      = owner_q;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
